// File: rtl/bin_to_glyph.sv
// Sequential double-dabble converter producing four 5-bit 7-seg glyph codes.
// Optional LEADING_BLANK_EN blanks leading zero digits (ones always shown).
module bin_to_glyph #(
  parameter int IN_W    = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [19:0]     num
);

  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  logic [IN_W-1:0] sh;
  logic [15:0]     bcd;
  logic [CW-1:0]   cnt;
  logic            ovf;
  logic [15:0]     bcd_adj;
  logic [19:0]     glyph;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    glyph = {1'b0, bcd[15:12], 1'b0, bcd[11:8],
             1'b0, bcd[7:4],   1'b0, bcd[3:0]};
`ifdef LEADING_BLANK_EN
    if (bcd[15:12] == 4'd0) begin
      glyph[19:15] = 5'd31;
      if (bcd[11:8] == 4'd0) begin
        glyph[14:10] = 5'd31;
        if (bcd[7:4] == 4'd0)
          glyph[9:5] = 5'd31;
      end
    end
`endif
    // "----" overrides whatever the BCD register holds
    if (ovf)
      glyph = 20'hD6B5A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      bcd   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      num   <= 20'hFFFFF;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh    <= bin;
            bcd   <= '0;
            cnt   <= CW'(IN_W);
            ovf   <= {{(32-IN_W){1'b0}}, bin} > 32'(MAX_VAL);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            bcd <= 16'({bcd_adj, sh[IN_W-1]});
            sh  <= {sh[IN_W-2:0], 1'b0};
            cnt <= cnt - CW'(1);
          end else begin
            num   <= glyph;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_glyph.sv
// Directed table-driven bench for bin_to_glyph, plus abort/ignore sequences.
// Expected glyphs follow LEADING_BLANK_EN when the bench is built with it.
module tb_bin_to_glyph;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic        busy;
  logic        done;
  logic [19:0] num;

  int total = 0;
  int bad   = 0;

  bin_to_glyph dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .num   (num)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] b;
    logic [19:0] eb;
    logic [19:0] ep;
  } vec_t;

  vec_t v[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] pick(input vec_t x);
`ifdef LEADING_BLANK_EN
    return x.eb;
`else
    return x.ep;
`endif
  endfunction

  task automatic conv(input logic [13:0] b, output logic [19:0] n,
                      output int lat);
    @(negedge clk);
    bin   = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    n = num;
    chk("busy_with_done", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("num_held", 32'(num), 32'(n));
  endtask

  initial begin
    logic [19:0] n;
    int lat;
    int dones;

    v[0]  = '{14'd1234,  20'h08864, 20'h08864};
    v[1]  = '{14'd7,     20'hFFFE7, 20'h00007};
    v[2]  = '{14'd0,     20'hFFFE0, 20'h00000};
    v[3]  = '{14'd9999,  20'h4A529, 20'h4A529};
    v[4]  = '{14'd10000, 20'hD6B5A, 20'hD6B5A};
    v[5]  = '{14'd42,    20'hFFC82, 20'h00082};
    v[6]  = '{14'd5678,  20'h298E8, 20'h298E8};
    v[7]  = '{14'd305,   20'hF8C05, 20'h00C05};
    v[8]  = '{14'd1000,  20'h08000, 20'h08000};
    v[9]  = '{14'd16383, 20'hD6B5A, 20'hD6B5A};
    v[10] = '{14'd56,    20'hFFCA6, 20'h000A6};

    // reset state
    @(posedge clk);
    #1;
    chk("rst_num", 32'(num), 32'hFFFFF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_num", 32'(num), 32'hFFFFF);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 11; i++) begin
      conv(v[i].b, n, lat);
      chk($sformatf("lat_%0d", v[i].b), 32'(lat), 32'd15);
      chk($sformatf("num_%0d", v[i].b), 32'(n), 32'(pick(v[i])));
    end

    // starts while busy are ignored; bin changes after accept are ignored
    @(negedge clk);
    bin   = 14'd1234;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = 14'd5678;
    dones = 0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
      start = (i == 2 || i == 13);
    end
    start = 1'b0;
    chk("busy_start_dones", 32'(dones), 32'd1);
    chk("busy_start_num", 32'(num), 32'h08864);
    chk("busy_start_idle", 32'(busy), 32'd0);
    conv(14'd5678, n, lat);
    chk("after_busy_num", 32'(n), 32'(pick(v[6])));

    // asynchronous abort mid-conversion
    @(negedge clk);
    bin   = 14'd1234;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_num", 32'(num), 32'hFFFFF);
    chk("abort_done", 32'(done), 32'd0);
    dones = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (done) dones++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1 if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    conv(14'd56, n, lat);
    chk("abort_recover_lat", 32'(lat), 32'd15);
    chk("abort_recover_num", 32'(n), 32'(pick(v[10])));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
